// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISALIGN = 2'd1;
  localparam logic [1:0] FC_RANGE    = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular skid FIFO holding fetched {pc, instr} entries; flush dominates push.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  fetch_entry_t             din_i,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  rd_q, rd_d;
  logic [AW-1:0]  wr_q, wr_d;
  logic [AW:0]    cnt_q, cnt_d;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + 1'b1;
      if (pop_i)  rd_d = rd_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, pushes {pc, instr} into the skid FIFO, handles redirect/halt/fault.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned DEPTH      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  input  logic        resume,
  output logic        halted,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fetch_count
);

  localparam logic [XLEN:0] PC_LIMIT = (XLEN+1)'(IMEM_WORDS * INSTR_BYTES);

  fetch_state_e          state_q, state_d;
  logic [XLEN-1:0]       pc_q, pc_d;
  logic [1:0]            cause_q, cause_d;
  logic [31:0]           fcnt_q, fcnt_d;

  logic                  push, pop, flush, slot_free, in_range;
  logic                  fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  fetch_entry_t          fifo_din, fifo_head;

  assign pop       = !fifo_empty && out_ready;
  assign slot_free = !fifo_full || pop;
  assign in_range  = ({1'b0, pc_q} < PC_LIMIT);

  // Redirect outranks everything; halt outranks fetch and the range check.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cause_d = cause_q;
    push    = 1'b0;
    flush   = 1'b0;
    if (redirect_valid) begin
      flush = 1'b1;
      if (redirect_pc[1:0] != 2'b00) begin
        state_d = ST_FAULT;
        cause_d = FC_MISALIGN;
      end else begin
        pc_d    = redirect_pc;
        state_d = ST_RUN;
        cause_d = FC_NONE;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (halt_req) begin
            state_d = ST_HALT;
          end else if (slot_free) begin
            if (in_range) begin
              push = 1'b1;
              pc_d = pc_q + XLEN'(INSTR_BYTES);
            end else begin
              state_d = ST_FAULT;
              cause_d = FC_RANGE;
            end
          end
        end
        ST_HALT:  if (resume) state_d = ST_RUN;
        default:  state_d = state_q;
      endcase
    end
  end

  assign fcnt_d = fcnt_q + {31'd0, push};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      cause_q <= FC_NONE;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign fifo_din = '{pc: pc_q, instr: imem_instr};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .din_i   (fifo_din),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign imem_addr   = pc_q;
  assign out_valid   = (fifo_count != '0);
  assign out_pc      = fifo_head.pc;
  assign out_instr   = fifo_head.instr;
  assign halted      = (state_q == ST_HALT);
  assign fault       = (state_q == ST_FAULT);
  assign fault_cause = cause_q;
  assign fetch_count = fcnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: memory word i holds 32'h1000_0000 + i.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr, imem_instr;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req, resume;
  logic        halted, fault;
  logic [1:0]  fault_cause;
  logic [31:0] fetch_count;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  assign imem_instr = 32'h1000_0000 + {2'b00, imem_addr[31:2]};

  fetch_ctrl #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_WORDS(256),
    .DEPTH     (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt_req      (halt_req),
    .resume        (resume),
    .halted        (halted),
    .fault         (fault),
    .fault_cause   (fault_cause),
    .fetch_count   (fetch_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic ready);
    @(negedge clk);
    rst_n          = 1'b0;
    out_ready      = ready;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt_req       = 1'b0;
    resume         = 1'b0;
    step(2);
    check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_addr",  imem_addr, 32'h0);
    check_eq("rst_halt",  {31'd0, halted}, 32'd0);
    check_eq("rst_fault", {31'd0, fault}, 32'd0);
    check_eq("rst_cause", {30'd0, fault_cause}, 32'd0);
    check_eq("rst_fcnt",  fetch_count, 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    // Streaming with ready held high.
    do_reset(1'b1);
    for (int k = 1; k <= 4; k++) begin
      step(1);
      check_eq("str_valid", {31'd0, out_valid}, 32'd1);
      check_eq("str_pc",    out_pc, 32'(4 * (k - 1)));
      check_eq("str_instr", out_instr, 32'h1000_0000 + 32'(k - 1));
      check_eq("str_fcnt",  fetch_count, 32'(k));
      check_eq("str_addr",  imem_addr, 32'(4 * k));
    end

    // Backpressure: FIFO fills to two, PC stalls at 8.
    do_reset(1'b0);
    step(5);
    check_eq("bp_valid", {31'd0, out_valid}, 32'd1);
    check_eq("bp_head",  out_pc, 32'h0);
    check_eq("bp_addr",  imem_addr, 32'h8);
    check_eq("bp_fcnt",  fetch_count, 32'd2);
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step(1);
      check_eq("bp_drain_pc", out_pc, 32'(4 * (j + 1)));
    end
    check_eq("bp_fcnt2", fetch_count, 32'd5);

    // Redirect while full.
    out_ready = 1'b0;
    step(1);
    check_eq("rd_pre_head", out_pc, 32'hC);
    check_eq("rd_pre_addr", imem_addr, 32'h14);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step(1);
    redirect_valid = 1'b0;
    check_eq("rd_flush", {31'd0, out_valid}, 32'd0);
    check_eq("rd_addr",  imem_addr, 32'h40);
    out_ready = 1'b1;
    step(1);
    check_eq("rd_valid", {31'd0, out_valid}, 32'd1);
    check_eq("rd_pc",    out_pc, 32'h40);
    check_eq("rd_instr", out_instr, 32'h1000_0010);

    // Misaligned redirect faults; resume is ignored; aligned redirect recovers.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    step(1);
    redirect_valid = 1'b0;
    check_eq("mis_fault", {31'd0, fault}, 32'd1);
    check_eq("mis_cause", {30'd0, fault_cause}, 32'd1);
    check_eq("mis_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mis_addr",  imem_addr, 32'h44);
    resume = 1'b1;
    step(1);
    resume = 1'b0;
    step(2);
    check_eq("mis_hold_fault", {31'd0, fault}, 32'd1);
    check_eq("mis_hold_fcnt",  fetch_count, 32'd6);
    check_eq("mis_hold_valid", {31'd0, out_valid}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    step(1);
    redirect_valid = 1'b0;
    check_eq("rec_fault", {31'd0, fault}, 32'd0);
    check_eq("rec_cause", {30'd0, fault_cause}, 32'd0);
    check_eq("rec_addr",  imem_addr, 32'h20);
    step(1);
    check_eq("rec_pc",    out_pc, 32'h20);
    check_eq("rec_instr", out_instr, 32'h1000_0008);
    check_eq("rec_fcnt",  fetch_count, 32'd7);

    // Range fault at the top of memory, buffered entries still drain.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3F8;
    step(1);
    redirect_valid = 1'b0;
    step(1);
    check_eq("rng_pc0", out_pc, 32'h3F8);
    out_ready = 1'b0;
    step(1);
    check_eq("rng_addr", imem_addr, 32'h400);
    check_eq("rng_fcnt", fetch_count, 32'd9);
    out_ready = 1'b1;
    step(1);
    check_eq("rng_fault", {31'd0, fault}, 32'd1);
    check_eq("rng_cause", {30'd0, fault_cause}, 32'd2);
    check_eq("rng_drain_valid", {31'd0, out_valid}, 32'd1);
    check_eq("rng_drain_pc",    out_pc, 32'h3FC);
    check_eq("rng_drain_instr", out_instr, 32'h1000_00FF);
    check_eq("rng_addr2", imem_addr, 32'h400);
    step(1);
    check_eq("rng_empty", {31'd0, out_valid}, 32'd0);
    check_eq("rng_fcnt2", fetch_count, 32'd9);

    // Halt, drain, resume, halt again, then async reset mid-HALT.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8;
    step(1);
    redirect_valid = 1'b0;
    step(2);
    check_eq("h_pre_head", out_pc, 32'hC);
    check_eq("h_pre_addr", imem_addr, 32'h10);
    halt_req  = 1'b1;
    out_ready = 1'b0;
    step(1);
    check_eq("h_halted", {31'd0, halted}, 32'd1);
    check_eq("h_addr",   imem_addr, 32'h10);
    check_eq("h_fcnt",   fetch_count, 32'd11);
    check_eq("h_head",   out_pc, 32'hC);
    out_ready = 1'b1;
    step(1);
    check_eq("h_drained", {31'd0, out_valid}, 32'd0);
    check_eq("h_fcnt2",   fetch_count, 32'd11);
    halt_req = 1'b0;
    resume   = 1'b1;
    step(1);
    resume = 1'b0;
    check_eq("res_halted", {31'd0, halted}, 32'd0);
    check_eq("res_addr",   imem_addr, 32'h10);
    step(1);
    check_eq("res_pc",    out_pc, 32'h10);
    check_eq("res_instr", out_instr, 32'h1000_0004);
    check_eq("res_fcnt",  fetch_count, 32'd12);
    halt_req = 1'b1;
    step(1);
    check_eq("h2_halted", {31'd0, halted}, 32'd1);
    check_eq("h2_valid",  {31'd0, out_valid}, 32'd0);
    check_eq("h2_addr",   imem_addr, 32'h14);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_halted", {31'd0, halted}, 32'd0);
    check_eq("arst_addr",   imem_addr, 32'h0);
    check_eq("arst_fcnt",   fetch_count, 32'd0);
    check_eq("arst_valid",  {31'd0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
